serial_ripple_subtractor: RTL and testbench
===========================================

// Module: serial_ripple_subtractor
//
// PURPOSE
//   Bit-serial two's-complement subtractor. Computes DIFF = A - B over WIDTH clock
//   cycles using a single full-subtractor cell and a registered borrow, one bit per
//   cycle, LSB first. It is the inverse-operation companion to the parallel adders
//   in this library, intended for area-constrained datapaths. Operands are taken
//   through a START/BUSY/DONE/ACK handshake.
//
// PARAMETERS
//   WIDTH   6   operand/result width in bits; legal range WIDTH >= 2
//
// PORTS
//   CLK    in   1      clock, rising edge
//   RST    in   1      reset, asynchronous, active-high
//   START  in   1      request; sampled only in IDLE
//   A      in   WIDTH  minuend, captured on the START edge
//   B      in   WIDTH  subtrahend, captured on the START edge
//   ACK    in   1      consumer accepts result; sampled only in DONE
//   BUSY   out  1      high in RUN and DONE (operands not accepted)
//   DONE   out  1      result valid; held until ACK
//   DIFF   out  WIDTH  A - B modulo 2^WIDTH
//   BOUT   out  1      final borrow: 1 iff A < B (unsigned)
//   OVF    out  1      signed overflow of A - B
//
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE; BUSY=DONE=BOUT=OVF=0; DIFF=0; bit counter,
//     borrow, operand shift registers cleared. Reset during RUN aborts the operation
//     without producing a result.
//   - FSM states: IDLE, RUN, DONE.
//     IDLE: START=1 at an edge -> capture A, B; borrow=0; count=0; -> RUN. DIFF, BOUT and OVF
//       keep their last value until the next capture.
//     RUN: each edge processes bit i=count: d = a_i ^ b_i ^ br;
//       br_next = (~a_i & b_i) | (~a_i & br) | (b_i & br); d shifts in at DIFF MSB (shift
//       right), operand registers shift right, count++. After the edge processing
//       bit WIDTH-1 -> DONE; BOUT = br_next of that bit;
//       OVF = (A[WIDTH-1] != B[WIDTH-1]) & (DIFF[WIDTH-1] != A[WIDTH-1]), with A and B taken
//       from the captured copies.
//     DONE: DONE=1; DIFF/BOUT/OVF stable. ACK=1 at an edge -> IDLE; DONE drops that edge.
//   - Latency: START sampled at edge 0; DONE is high after edge WIDTH (WIDTH cycles).
//     Minimum start-to-start spacing is WIDTH+2 cycles (ACK on the first DONE cycle).
//   - DIFF is not valid while BUSY=1 and DONE=0; it is partially shifted during RUN.
//   - START in RUN or DONE is ignored; it is not queued. START and ACK in the same DONE
//     cycle: only ACK takes effect, and START must be re-presented in IDLE.
//   - ACK outside DONE is ignored. A and B changes after the capture edge have no effect.
//   - Counter width is clog2(WIDTH)+1 and it does not wrap during RUN.
//
// TESTING
//   1. A=45, B=17, START 1 cycle -> DONE after 6 cycles; DIFF=28, BOUT=0, OVF=0;
//      BUSY high from edge 0 until ACK.
//   2. A=5, B=9 -> DIFF=60 (6'b111100), BOUT=1, OVF=0; A=0, B=1 -> DIFF=63, BOUT=1.
//   3. A=6'b100000 (-32), B=1 -> DIFF=31, BOUT=0, OVF=1; A=31, B=6'b111111 (-1) ->
//      DIFF=32, OVF=1, BOUT=1.
//   4. A=B=63 -> DIFF=0, BOUT=0, OVF=0; hold ACK low 10 cycles -> DONE and DIFF stay stable.
//   5. START pulsed during RUN and again with ACK in DONE -> neither starts a new op;
//      back-to-back ops with ACK on the first DONE cycle -> start spacing of 8 cycles.
//   6. RST asserted after 3 RUN cycles -> all outputs 0 immediately, state IDLE;
//      next START with A=10, B=3 -> DIFF=7 after 6 cycles.

Source files
------------

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell and a registered
// borrow produce A - B LSB first over WIDTH cycles behind a START/BUSY/DONE/ACK handshake.
module serial_ripple_subtractor #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ack,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, diff_q;
   logic [CW-1:0]    cnt;
   logic             br, bout_q, ovf_q;
   logic             ai, bi, d, br_nxt, last;

   // Full-subtractor cell on the current LSBs of the operand shift registers
   always_comb begin
      ai     = a_sh[0];
      bi     = b_sh[0];
      d      = ai ^ bi ^ br;
      br_nxt = (~ai & bi) | (~ai & br) | (bi & br);
      last   = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (last)  state_nxt = S_DONE;
         S_DONE:  if (ack)   state_nxt = S_IDLE;
         default:            state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         diff_q <= '0;
         cnt    <= '0;
         br     <= 1'b0;
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  br     <= 1'b0;
                  cnt    <= '0;
                  bout_q <= 1'b0;
                  ovf_q  <= 1'b0;
               end
            end
            S_RUN: begin
               diff_q <= {d, diff_q[WIDTH-1:1]};
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               br     <= br_nxt;
               cnt    <= cnt + CW'(1);
               // On the MSB step ai/bi are the captured sign bits and d is the result sign
               if (last) begin
                  bout_q <= br_nxt;
                  ovf_q  <= (ai != bi) & (d != ai);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);
   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor: directed and random operations
// compared against an arithmetic model of A - B, plus handshake and reset scenarios.
module tb_serial_ripple_subtractor;

   localparam int W = 6;

   logic         clk, rst, start, ack;
   logic [W-1:0] a, b;
   logic         busy, done, bout, ovf;
   logic [W-1:0] diff;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   serial_ripple_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ack(ack),
      .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic model_ovf(input logic [W-1:0] av, input logic [W-1:0] bv);
      int sa, sb, r;
      sa = $signed(av);
      sb = $signed(bv);
      r  = sa - sb;
      return (r < -(2 ** (W - 1))) || (r > (2 ** (W - 1)) - 1);
   endfunction

   // Issue one operation and wait (bounded) for DONE; result is left pending
   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit scramble);
      int           n;
      logic [W-1:0] ed;
      logic         eb, eo;
      ed = av - bv;
      eb = (av < bv);
      eo = model_ovf(av, bv);
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nvec++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         nerr++;
         $display("FAIL run_flags a=%0d b=%0d: busy=%b done=%b, required busy=1 done=0", av, bv, busy, done);
      end
      n = 0;
      while (done !== 1'b1 && n < 3 * W) begin
         if (scramble) begin
            a = W'($urandom);
            b = W'($urandom);
         end
         @(negedge clk);
         n++;
      end
      nvec++;
      if (n !== W) begin
         nerr++;
         $display("FAIL latency a=%0d b=%0d: %0d cycles, required %0d", av, bv, n, W);
      end
      nvec++;
      if (diff !== ed || bout !== eb || ovf !== eo || busy !== 1'b1) begin
         nerr++;
         $display("FAIL result a=%0d b=%0d: diff=%0d bout=%b ovf=%b busy=%b, required diff=%0d bout=%b ovf=%b busy=1",
                  av, bv, diff, bout, ovf, busy, ed, eb, eo);
      end
   endtask

   task automatic do_ack();
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      nvec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         nerr++;
         $display("FAIL ack_release: done=%b busy=%b, required done=0 busy=0", done, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; ack = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      nvec++;
      if ({busy, done, bout, ovf} !== 4'b0 || diff !== '0) begin
         nerr++;
         $display("FAIL reset_state: busy=%b done=%b bout=%b ovf=%b diff=%0d, required all 0", busy, done, bout, ovf, diff);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [W-1:0] va [8] = '{6'd45, 6'd5, 6'd0, 6'd32, 6'd31, 6'd0, 6'd63, 6'd17};
      logic [W-1:0] vb [8] = '{6'd17, 6'd9, 6'd1, 6'd1, 6'd63, 6'd0, 6'd0, 6'd45};
      for (int i = 0; i < 8; i++) begin
         do_op(va[i], vb[i], 1'b0);
         do_ack();
      end
   endtask

   task automatic test_hold_done();
      do_op(6'd63, 6'd63, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         nvec++;
         if (done !== 1'b1 || diff !== '0 || bout !== 1'b0 || ovf !== 1'b0) begin
            nerr++;
            $display("FAIL hold_stable cycle %0d: done=%b diff=%0d bout=%b ovf=%b, required done=1 diff=0 bout=0 ovf=0",
                     i, done, diff, bout, ovf);
         end
      end
      do_ack();
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         do_op(W'($urandom), W'($urandom), 1'b1);
         do_ack();
      end
   endtask

   task automatic test_start_ignored();
      int n;
      @(negedge clk);
      a = 6'd20; b = 6'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 6'd0; b = 6'd33; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 3 * W) begin
         @(negedge clk);
         n++;
      end
      nvec++;
      if (done !== 1'b1 || diff !== 6'd15) begin
         nerr++;
         $display("FAIL start_in_run: done=%b diff=%0d, required done=1 diff=15", done, diff);
      end
      ack = 1'b1; start = 1'b1; a = 6'd1; b = 6'd2;
      @(negedge clk);
      ack = 1'b0; start = 1'b0;
      nvec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         nerr++;
         $display("FAIL start_with_ack: done=%b busy=%b, required 0 0", done, busy);
      end
      @(negedge clk);
      nvec++;
      if (busy !== 1'b0) begin
         nerr++;
         $display("FAIL start_not_queued: busy=%b, required 0", busy);
      end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      nvec++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== 6'd15) begin
         nerr++;
         $display("FAIL ack_in_idle: busy=%b done=%b diff=%0d, required 0 0 15", busy, done, diff);
      end
   endtask

   task automatic test_back_to_back();
      int c0, c1;
      do_op(6'd40, 6'd2, 1'b0);
      c0 = cyc - W;
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      a = 6'd7; b = 6'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c1 = cyc;
      nvec++;
      if (c1 - c0 !== W + 2 || busy !== 1'b1) begin
         nerr++;
         $display("FAIL start_spacing: %0d cycles busy=%b, required %0d busy=1", c1 - c0, busy, W + 2);
      end
      repeat (W) @(negedge clk);
      nvec++;
      if (done !== 1'b1 || diff !== 6'd62 || bout !== 1'b1 || ovf !== 1'b0) begin
         nerr++;
         $display("FAIL back_to_back_result: done=%b diff=%0d bout=%b ovf=%b, required 1 62 1 0", done, diff, bout, ovf);
      end
      do_ack();
   endtask

   task automatic test_reset_abort();
      do_op(6'd50, 6'd7, 1'b0);
      do_ack();
      @(negedge clk);
      a = 6'd33; b = 6'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      nvec++;
      if ({busy, done, bout, ovf} !== 4'b0 || diff !== '0) begin
         nerr++;
         $display("FAIL reset_abort: busy=%b done=%b bout=%b ovf=%b diff=%0d, required all 0", busy, done, bout, ovf, diff);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      nvec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         nerr++;
         $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
      end
      do_op(6'd10, 6'd3, 1'b0);
      do_ack();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold_done();
      test_random();
      test_start_ignored();
      test_back_to_back();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
